// File: rtl/booth_encoder.sv
// Radix-4 Booth encoder for a single partial-product row of the Barrett
// modular multiplier. The 3-bit multiplier window selects one of
// {0, +Y, +2Y, -Y, -2Y}. A negative row is emitted as the one's complement
// of the magnitude, and sign=1 tells the compression tree to add the
// missing +1 at this row's LSB.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   qualifies x_low/x/x_high/y this cycle
//   x_low      multiplier bit b(2i-1); 0 for the LSB digit
//   x          multiplier bit b(2i)
//   x_high     multiplier bit b(2i+1)
//   y          unsigned multiplicand, n bits
//   out_valid  pp/sign hold the result of an accepted input
//   sign       1 = negative digit; add +1 at this row's LSB
//   pp         encoded partial product, n+1 bits
module booth_encoder #(
    parameter int unsigned n = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic         x_low,
    input  logic         x,
    input  logic         x_high,
    input  logic [n-1:0] y,
    output logic         out_valid,
    output logic         sign,
    output logic [n:0]   pp
);

    localparam int unsigned PP_W = n + 1;

    logic            one_c;
    logic            two_c;
    logic            neg_c;
    logic [PP_W-1:0] y_ext_c;
    logic [PP_W-1:0] y_dbl_c;
    logic [PP_W-1:0] pp_c;

    // Window decode. Window 111 gives neg=0, so there is never a -0 row.
    always_comb begin
        one_c   = x ^ x_low;
        two_c   = (x_high & ~x & ~x_low) | (~x_high & x & x_low);
        neg_c   = x_high & ~(x & x_low);
        y_ext_c = {1'b0, y};
        y_dbl_c = {y, 1'b0};
        pp_c    = {PP_W{neg_c}} ^ (({PP_W{one_c}} & y_ext_c) |
                                   ({PP_W{two_c}} & y_dbl_c));
    end

    // Output register. pp/sign hold their value while no input is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sign      <= 1'b0;
            pp        <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sign <= neg_c;
                pp   <= pp_c;
            end
        end
    end

endmodule

// File: tb/tb_booth_encoder.sv
module tb_booth_encoder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       x_low;
    logic       x;
    logic       x_high;
    logic [7:0] y;
    logic       out_valid;
    logic       sign;
    logic [8:0] pp;

    int total;
    int bad;

    booth_encoder #(.n(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .x_low     (x_low),
        .x         (x),
        .x_high    (x_high),
        .y         (y),
        .out_valid (out_valid),
        .sign      (sign),
        .pp        (pp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-written truth table: returns {sign, pp}.
    function automatic logic [9:0] model(input logic [2:0] w, input logic [7:0] yv);
        logic [8:0] m1;
        logic [8:0] m2;
        m1 = {1'b0, yv};
        m2 = {yv, 1'b0};
        case (w)
            3'b001, 3'b010: model = {1'b0, m1};
            3'b011:         model = {1'b0, m2};
            3'b100:         model = {1'b1, ~m2};
            3'b101, 3'b110: model = {1'b1, ~m1};
            default:        model = 10'd0;
        endcase
    endfunction

    function automatic int digit_of(input logic [2:0] w);
        case (w)
            3'b001, 3'b010: digit_of = 1;
            3'b011:         digit_of = 2;
            3'b100:         digit_of = -2;
            3'b101, 3'b110: digit_of = -1;
            default:        digit_of = 0;
        endcase
    endfunction

    // Present one valid input and sample #1 after the capturing edge.
    task automatic apply(input logic [2:0] w, input logic [7:0] yv);
        in_valid = 1'b1;
        {x_high, x, x_low} = w;
        y = yv;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b1;
        {x_high, x, x_low} = 3'b011;
        y = 8'hFF;
        #1;
        total++;
        if ({out_valid, sign, pp} !== 11'd0) begin
            bad++;
            $display("FAIL reset_state: got ov=%b sign=%b pp=%h, want 0/0/000", out_valid, sign, pp);
        end
        @(posedge clk);
        #1;
        total++;
        if ({out_valid, sign, pp} !== 11'd0) begin
            bad++;
            $display("FAIL reset_hold_edge: got ov=%b sign=%b pp=%h, want 0/0/000", out_valid, sign, pp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic test_directed;
        logic [2:0]  w   [7] = '{3'b110, 3'b011, 3'b010, 3'b100, 3'b000, 3'b111, 3'b001};
        logic [9:0]  exp [7] = '{{1'b1, 9'h156}, {1'b0, 9'h152}, {1'b0, 9'h0A9},
                                 {1'b1, 9'h0AD}, 10'd0, 10'd0, {1'b0, 9'h0A9}};
        for (int i = 0; i < 7; i++) begin
            apply(w[i], 8'hA9);
            total++;
            if ({out_valid, sign, pp} !== {1'b1, exp[i]}) begin
                bad++;
                $display("FAIL directed_w%b: got ov=%b sign=%b pp=%h, want ov=1 sign=%b pp=%h",
                         w[i], out_valid, sign, pp, exp[i][9], exp[i][8:0]);
            end
        end
    endtask

    task automatic test_boundaries;
        // y=0: positive digits give 0, negative give all ones with sign
        apply(3'b011, 8'h00);
        total++;
        if ({sign, pp} !== 10'd0) begin
            bad++;
            $display("FAIL y0_pos2: got sign=%b pp=%h, want 0/000", sign, pp);
        end
        apply(3'b100, 8'h00);
        total++;
        if ({sign, pp} !== {1'b1, 9'h1FF}) begin
            bad++;
            $display("FAIL y0_neg2: got sign=%b pp=%h, want 1/1ff", sign, pp);
        end
        // y all ones with +2Y / -2Y
        apply(3'b011, 8'hFF);
        total++;
        if ({sign, pp} !== {1'b0, 9'h1FE}) begin
            bad++;
            $display("FAIL yff_pos2: got sign=%b pp=%h, want 0/1fe", sign, pp);
        end
        apply(3'b100, 8'hFF);
        total++;
        if ({sign, pp} !== {1'b1, 9'h001}) begin
            bad++;
            $display("FAIL yff_neg2: got sign=%b pp=%h, want 1/001", sign, pp);
        end
    endtask

    task automatic test_exhaustive;
        logic [9:0] e;
        int d;
        int lhs;
        int rhs;
        for (int yy = 0; yy < 256; yy++) begin
            for (int wi = 0; wi < 8; wi++) begin
                apply(3'(wi), 8'(yy));
                e = model(3'(wi), 8'(yy));
                d = digit_of(3'(wi));
                lhs = (int'(pp) + int'(sign)) & 511;
                rhs = (d * yy) & 511;
                total++;
                if ({out_valid, sign, pp} !== {1'b1, e} || lhs != rhs) begin
                    bad++;
                    $display("FAIL exh y=%h w=%b: got ov=%b sign=%b pp=%h (sum %0d), want sign=%b pp=%h (sum %0d)",
                             8'(yy), 3'(wi), out_valid, sign, pp, lhs, e[9], e[8:0], rhs);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        apply(3'b001, 8'h3C);
        total++;
        if ({out_valid, sign, pp} !== {2'b10, 9'h03C}) begin
            bad++;
            $display("FAIL b2b_first: got ov=%b sign=%b pp=%h, want 1/0/03c", out_valid, sign, pp);
        end
        apply(3'b101, 8'h5A);
        total++;
        if ({out_valid, sign, pp} !== {2'b11, 9'h1A5}) begin
            bad++;
            $display("FAIL b2b_second: got ov=%b sign=%b pp=%h, want 1/1/1a5", out_valid, sign, pp);
        end
        // Bubble with different data on the pins: outputs must hold
        in_valid = 1'b0;
        {x_high, x, x_low} = 3'b011;
        y = 8'hFF;
        @(posedge clk);
        #1;
        total++;
        if ({out_valid, sign, pp} !== {2'b01, 9'h1A5}) begin
            bad++;
            $display("FAIL b2b_bubble: got ov=%b sign=%b pp=%h, want 0/1/1a5", out_valid, sign, pp);
        end
        apply(3'b011, 8'h81);
        total++;
        if ({out_valid, sign, pp} !== {2'b10, 9'h102}) begin
            bad++;
            $display("FAIL b2b_resume: got ov=%b sign=%b pp=%h, want 1/0/102", out_valid, sign, pp);
        end
    endtask

    task automatic test_reset_midstream;
        apply(3'b110, 8'h77);
        in_valid = 1'b1;
        {x_high, x, x_low} = 3'b010;
        y = 8'h12;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, sign, pp} !== 11'd0) begin
            bad++;
            $display("FAIL midreset_immediate: got ov=%b sign=%b pp=%h, want 0/0/000", out_valid, sign, pp);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        total++;
        if ({out_valid, sign, pp} !== 11'd0) begin
            bad++;
            $display("FAIL midreset_release: got ov=%b sign=%b pp=%h, want 0/0/000", out_valid, sign, pp);
        end
        @(posedge clk);
        #1;
        total++;
        if ({out_valid, sign, pp} !== {2'b10, 9'h012}) begin
            bad++;
            $display("FAIL midreset_first: got ov=%b sign=%b pp=%h, want 1/0/012", out_valid, sign, pp);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_directed();
        test_boundaries();
        test_exhaustive();
        test_back_to_back();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
